kb_sched: RTL and testbench

Candidate-key scheduler for the RSA/AES key-search path. Sweeps an inclusive counter range of candidate key blocks across `N_WORKERS` `aes_kb` checker instances. Issues one-cycle `start` pulses to idle workers and tracks which counter value each worker holds. Collects `done`/`valid` results and reports the matching counter value, the number of candidates tested and a completion pulse. Sits between the host control registers and the `aes_kb` array; the wrapper builds each worker's `kb` as `{kb_base[447:CTR_W], w_ctr[i]}`.

---
 rtl/kb_sched_if.sv | 31 +++
 rtl/kb_sched.sv | 109 ++++++++++
 tb/tb_kb_sched.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/kb_sched_if.sv
// kb_sched_if: host control and aes_kb worker-array signals of the candidate-key scheduler.
interface kb_sched_if #(
  parameter int N_WORKERS = 4,
  parameter int CTR_W = 32
);
  logic stall;
  logic go;
  logic abort;
  logic [CTR_W-1:0] ctr_lo;
  logic [CTR_W-1:0] ctr_hi;
  logic [127:0] in_buf;
  logic [127:0] w_in_buf;
  logic [N_WORKERS-1:0] w_start;
  logic [N_WORKERS*CTR_W-1:0] w_ctr;
  logic [N_WORKERS-1:0] w_done;
  logic [N_WORKERS-1:0] w_valid;
  logic busy;
  logic done;
  logic found;
  logic [CTR_W-1:0] found_ctr;
  logic [CTR_W:0] tested;
  logic [7:0] hit_cnt;
  modport master (
    output stall, go, abort, ctr_lo, ctr_hi, in_buf, w_done, w_valid,
    input w_in_buf, w_start, w_ctr, busy, done, found, found_ctr, tested, hit_cnt
  );
  modport slave (
    input stall, go, abort, ctr_lo, ctr_hi, in_buf, w_done, w_valid,
    output w_in_buf, w_start, w_ctr, busy, done, found, found_ctr, tested, hit_cnt
  );
endinterface

// File: rtl/kb_sched.sv
// kb_sched: sweeps an inclusive counter range across N_WORKERS aes_kb checkers and collects matches.
// Define KB_SCHED_EARLY_STOP_EN to stop issuing as soon as the first match is recorded.
module kb_sched #(
  parameter int N_WORKERS = 4,
  parameter int CTR_W = 32
) (
  input logic clk,
  input logic rst,
  kb_sched_if.slave b
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;
  state_t state, state_n;
  logic [CTR_W:0] next_q;
  logic [CTR_W:0] tested_q;
  logic [CTR_W:0] n_comp;
  logic [CTR_W-1:0] hi_q;
  logic [CTR_W-1:0] found_ctr_q;
  logic [CTR_W-1:0] hit_ctr;
  logic [CTR_W-1:0] ctr_q [N_WORKERS];
  logic [N_WORKERS-1:0] owned;
  logic [N_WORKERS-1:0] cand;
  logic [N_WORKERS-1:0] start;
  logic [N_WORKERS-1:0] comp;
  logic [N_WORKERS-1:0] hits;
  logic [N_WORKERS-1:0] hsel;
  logic [127:0] buf_q;
  logic [8:0] hit_sum;
  logic [7:0] hit_q;
  logic found_q;
  logic new_found;
  logic early;
  logic stop;
`ifdef KB_SCHED_EARLY_STOP_EN
  assign early = new_found;
`else
  assign early = 1'b0;
`endif
  always_comb begin
    comp = b.stall ? '0 : b.w_done & owned;
    hits = comp & b.w_valid;
    hsel = hits & (~hits + N_WORKERS'(1));
    new_found = !found_q && |hits;
    stop = b.abort || early;
    // aes_kb keeps done high after finishing, so a worker with done still up is not free yet
    cand = ~owned & ~b.w_done;
    start = (state == RUN && !b.stall && !stop) ? cand & (~cand + N_WORKERS'(1)) : '0;
    hit_ctr = '0;
    n_comp = '0;
    hit_sum = {1'b0, hit_q};
    for (int i = 0; i < N_WORKERS; i++) begin
      hit_ctr = hit_ctr | (hsel[i] ? ctr_q[i] : '0);
      n_comp = n_comp + (CTR_W+1)'(comp[i]);
      hit_sum = hit_sum + 9'(hits[i]);
    end
    case (state)
      IDLE: state_n = b.go ? ((b.ctr_lo <= b.ctr_hi) ? RUN : FIN) : IDLE;
      RUN: state_n = (stop || (|start && next_q >= {1'b0, hi_q})) ? DRAIN : RUN;
      DRAIN: state_n = |owned ? DRAIN : FIN;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      next_q <= '0;
      hi_q <= '0;
      owned <= '0;
      buf_q <= '0;
      found_q <= 1'b0;
      found_ctr_q <= '0;
      tested_q <= '0;
      hit_q <= '0;
      for (int i = 0; i < N_WORKERS; i++) ctr_q[i] <= '0;
    end else if (!b.stall) begin
      state <= state_n;
      owned <= (owned & ~comp) | start;
      for (int i = 0; i < N_WORKERS; i++) if (start[i]) ctr_q[i] <= next_q[CTR_W-1:0];
      if (state == IDLE && b.go) begin
        hi_q <= b.ctr_hi;
        next_q <= {1'b0, b.ctr_lo};
        buf_q <= b.in_buf;
        found_q <= 1'b0;
        found_ctr_q <= '0;
        tested_q <= '0;
        hit_q <= '0;
      end else begin
        next_q <= next_q + (CTR_W+1)'(|start);
        tested_q <= tested_q + n_comp;
        hit_q <= hit_sum[8] ? 8'hff : hit_sum[7:0];
        if (new_found) begin
          found_q <= 1'b1;
          found_ctr_q <= hit_ctr;
        end
      end
    end
  end
  // the issuing slice shows next directly so the worker sees its candidate with the start pulse
  for (genvar i = 0; i < N_WORKERS; i++) begin : g_ctr
    assign b.w_ctr[i*CTR_W +: CTR_W] = start[i] ? next_q[CTR_W-1:0] : ctr_q[i];
  end
  assign b.w_start = start;
  assign b.w_in_buf = buf_q;
  assign b.busy = (state == RUN) || (state == DRAIN);
  assign b.done = (state == FIN);
  assign b.found = found_q;
  assign b.found_ctr = found_ctr_q;
  assign b.tested = tested_q;
  assign b.hit_cnt = hit_q;
endmodule

// File: tb/tb_kb_sched.sv
// tb_kb_sched: randomized aes_kb worker models plus a sweep scoreboard checking kb_sched.
module tb_kb_sched;
  localparam int NW = 4;
  localparam int CW = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  kb_sched_if #(.N_WORKERS(NW), .CTR_W(CW)) bus();
  kb_sched #(.N_WORKERS(NW), .CTR_W(CW)) dut (.clk(clk), .rst(rst), .b(bus));
  int n_cmp = 0;
  int n_err = 0;
  logic [NW-1:0] m_owned;
  int m_val [NW];
  int m_next, m_hi, m_tested, m_hit, m_fctr, issued;
  bit m_found, m_stop, live, saw_done;
  int md = 1;
  int rs = 0;
  logic [127:0] exp_buf;
  int wst [NW];
  int wcnt [NW];
  bit wv [NW];
  bit fixed = 0;
  bit frc = 0;
  int flat [NW] = '{10, 2, 10, 0};
  logic [NW-1:0] s_start, s_done, s_valid;
  logic s_stall, s_rst, s_ab;
  int s_idx;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_match(input int v);
    return (v % md) == rs;
  endfunction

  task automatic drive();
    for (int i = 0; i < NW; i++) begin
      bus.w_done[i] = frc || (wst[i] == 2);
      bus.w_valid[i] = frc || (wst[i] == 2 && wv[i]);
    end
  endtask

  task automatic model_clear();
    m_owned = '0;
    m_next = 0;
    m_hi = 0;
    m_tested = 0;
    m_hit = 0;
    m_found = 0;
    m_fctr = 0;
    m_stop = 0;
    issued = 0;
    for (int i = 0; i < NW; i++) begin
      wst[i] = 0;
      m_val[i] = 0;
    end
  endtask

  task automatic cycle();
    int e_idx, hs;
    logic [NW-1:0] ev;
    @(negedge clk);
    s_start = bus.w_start;
    s_done = bus.w_done;
    s_valid = bus.w_valid;
    s_stall = bus.stall;
    s_rst = rst;
    s_ab = bus.abort;
    s_idx = -1;
    e_idx = -1;
    for (int i = NW - 1; i >= 0; i--) begin
      if (s_start[i]) s_idx = i;
      if (!m_owned[i] && !s_done[i]) e_idx = i;
    end
    if (s_stall) chk("stall_no_start", s_start, 0);
    if (m_stop) chk("no_issue_after_stop", s_start, 0);
    if (s_start != 0) begin
      ev = '0;
      if (e_idx >= 0) ev[e_idx] = 1'b1;
      chk("issue_sel", s_start, ev);
      chk("issue_ctr", bus.w_ctr[s_idx*CW +: CW], m_next);
      chk("issue_in_range", m_next <= m_hi, 1);
    end
    for (int i = 0; i < NW; i++)
      if (m_owned[i] && !s_start[i]) chk("ctr_hold", bus.w_ctr[i*CW +: CW], m_val[i]);
    if (live) begin
      chk("tested", bus.tested, m_tested);
      chk("hit_cnt", bus.hit_cnt, m_hit);
      chk("found", bus.found, m_found);
      chk("w_in_buf", bus.w_in_buf, exp_buf);
    end
    if (bus.done) begin
      saw_done = 1;
      chk("busy_at_done", bus.busy, 0);
      chk("found_ctr", bus.found_ctr, m_fctr);
      chk("drained", m_owned, 0);
    end
    @(posedge clk);
    #1;
    if (s_rst) model_clear();
    else if (!s_stall) begin
      hs = -1;
      for (int i = 0; i < NW; i++)
        if (s_done[i] && m_owned[i]) begin
          m_owned[i] = 1'b0;
          m_tested++;
          if (s_valid[i]) begin
            if (m_hit < 255) m_hit++;
            if (hs < 0) hs = i;
          end
        end
      if (hs >= 0 && !m_found) begin
        m_found = 1;
        m_fctr = m_val[hs];
`ifdef KB_SCHED_EARLY_STOP_EN
        m_stop = 1;
`endif
      end
      if (s_ab) m_stop = 1;
      for (int i = 0; i < NW; i++) begin
        if (wst[i] == 1) begin
          if (wcnt[i] == 0) begin
            wst[i] = 2;
            wcnt[i] = fixed ? 0 : int'($urandom_range(0, 2));
          end else wcnt[i]--;
        end else if (wst[i] == 2) begin
          if (wcnt[i] == 0) wst[i] = 0;
          else wcnt[i]--;
        end
      end
      if (s_idx >= 0) begin
        m_owned[s_idx] = 1'b1;
        m_val[s_idx] = m_next;
        wst[s_idx] = 1;
        wcnt[s_idx] = fixed ? flat[s_idx] : int'($urandom_range(0, 5));
        wv[s_idx] = is_match(m_next);
        m_next++;
        issued++;
      end
    end
    drive();
  endtask

  task automatic go_phase(input int lo, input int hi, input int imd, input int irs);
    md = imd;
    rs = irs;
    bus.ctr_lo = lo[CW-1:0];
    bus.ctr_hi = hi[CW-1:0];
    bus.in_buf = {$urandom, $urandom, $urandom, $urandom};
    bus.go = 1'b1;
    cycle();
    bus.go = 1'b0;
    exp_buf = bus.in_buf;
    live = 1;
    m_next = lo;
    m_hi = hi;
    m_tested = 0;
    m_hit = 0;
    m_found = 0;
    m_fctr = 0;
    m_stop = 0;
    issued = 0;
    saw_done = 0;
  endtask

  task automatic sweep(input int lo, input int hi, input int imd, input int irs, input int ab_at, input int st_at);
    int cyc, n, cnt;
    go_phase(lo, hi, imd, irs);
    cyc = 0;
    while (!saw_done && cyc < 3000) begin
      bus.abort = (cyc == ab_at);
      bus.stall = (st_at >= 0 && cyc >= st_at && cyc < st_at + 20);
      frc = bus.stall;
      drive();
      cycle();
      if (cyc == 0) begin
        chk("first_issue", s_start != 0, lo <= hi);
        chk("empty_done_timing", saw_done, lo > hi);
      end
      cyc++;
    end
    bus.abort = 1'b0;
    bus.stall = 1'b0;
    frc = 0;
    drive();
    if (!saw_done) chk("done_timeout", 0, 1);
    chk("done_one_cycle", bus.done, 0);
    chk("busy_after_done", bus.busy, 0);
    n = (lo <= hi) ? hi - lo + 1 : 0;
    cnt = 0;
    for (int v = lo; v <= hi; v++) if (is_match(v)) cnt++;
    if (bus.found) chk("found_ctr_is_match", is_match(int'(bus.found_ctr)), 1);
    if (ab_at < 0) begin
      chk("found_any", bus.found, cnt > 0);
`ifdef KB_SCHED_EARLY_STOP_EN
      chk("tested_issued", bus.tested, issued);
`else
      chk("tested_total", bus.tested, n);
      chk("issued_total", issued, n);
      chk("hit_total", bus.hit_cnt, (cnt > 255) ? 255 : cnt);
`endif
    end else chk("tested_issued_abort", bus.tested, issued);
  endtask

  initial begin
    bus.stall = 1'b0;
    bus.go = 1'b0;
    bus.abort = 1'b0;
    bus.ctr_lo = '0;
    bus.ctr_hi = '0;
    bus.in_buf = '0;
    exp_buf = '0;
    live = 0;
    model_clear();
    drive();
    rst = 1'b1;
    cycle();
    cycle();
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_found", bus.found, 0);
    chk("rst_found_ctr", bus.found_ctr, 0);
    chk("rst_tested", bus.tested, 0);
    chk("rst_hit", bus.hit_cnt, 0);
    chk("rst_w_start", bus.w_start, 0);
    chk("rst_w_ctr", bus.w_ctr, 0);
    chk("rst_w_in_buf", bus.w_in_buf, 0);
    rst = 1'b0;
    cycle();
    sweep(5, 5, 1, 0, -1, -1);
    chk("single_found", bus.found, 1);
    chk("single_found_ctr", bus.found_ctr, 5);
    chk("single_tested", bus.tested, 1);
    sweep(0, 9, 10, 6, -1, -1);
    chk("m6_found_ctr", bus.found_ctr, 6);
`ifdef KB_SCHED_EARLY_STOP_EN
    chk("m6_issued_range", issued >= 7 && issued <= 10, 1);
`else
    chk("m6_tested", bus.tested, 10);
`endif
    sweep(10, 3, 1, 0, -1, -1);
    chk("empty_found", bus.found, 0);
    chk("empty_tested", bus.tested, 0);
    sweep(0, 30, 5, 2, -1, 6);
    fixed = 1;
    sweep(0, 3, 2, 1, -1, -1);
    fixed = 0;
    chk("simul_found_ctr", bus.found_ctr, 1);
    chk("simul_hit", bus.hit_cnt, 2);
    chk("simul_tested", bus.tested, 4);
    sweep(65533, 65535, 2, 1, -1, -1);
    chk("top_tested", bus.tested, 3);
    sweep(0, 299, 1, 0, -1, -1);
`ifndef KB_SCHED_EARLY_STOP_EN
    chk("hit_saturate", bus.hit_cnt, 255);
`endif
    sweep(100, 400, 7, 3, 15, -1);
    chk("abort_short", issued < 301, 1);
    for (int k = 0; k < 6; k++) begin
      int lo, span, m;
      lo = int'($urandom_range(0, 1000));
      span = int'($urandom_range(0, 60));
      m = int'($urandom_range(3, 9));
      sweep(lo, lo + span, m, int'($urandom_range(0, m - 1)), -1, -1);
    end
    go_phase(0, 200, 3, 1);
    repeat (8) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_done", bus.done, 0);
    chk("mid_rst_found", bus.found, 0);
    chk("mid_rst_found_ctr", bus.found_ctr, 0);
    chk("mid_rst_tested", bus.tested, 0);
    chk("mid_rst_hit", bus.hit_cnt, 0);
    chk("mid_rst_w_start", bus.w_start, 0);
    chk("mid_rst_w_ctr", bus.w_ctr, 0);
    chk("mid_rst_w_in_buf", bus.w_in_buf, 0);
    exp_buf = '0;
    cycle();
    sweep(0, 5, 3, 0, -1, -1);
    chk("post_rst_tested", bus.tested, 6);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
